// File: rtl/steer_en_mc.sv
// Steering-enable controller: sums left/right load cells, tracks rider
// presence with hysteresis and gates steering behind a balance dwell.
module steer_en_mc #(
  parameter int               N_CELLS      = 4,
  parameter int               LD_W         = 12,
  parameter logic [LD_W-1:0]  MIN_RIDER_WT = 12'h200,
  parameter logic [LD_W-1:0]  HYST         = 12'h040,
  parameter int               BAL_SHIFT    = 2,
  parameter int               OFF_SHIFT    = 4,
  parameter int               TMR_W        = 26,
  parameter logic [TMR_W-1:0] TMR_FULL     = 26'd67_000_000,
  localparam int              SW           = LD_W + $clog2(N_CELLS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CELLS*LD_W-1:0] ld_cell,
  input  logic                    cell_vld,
  input  logic [N_CELLS-1:0]      cell_en,
  output logic [SW:0]             tot_ld,
  output logic signed [SW:0]      ld_cell_diff,
  output logic                    diff_vld,
  output logic                    en_steer,
  output logic                    rider_off,
  output logic [1:0]              state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_STEER = 2'd2
  } st_e;

  localparam logic [SW:0] ENTER_T =
    (SW+1)'(MIN_RIDER_WT);
  localparam logic [SW:0] EXIT_T =
    (SW+1)'(MIN_RIDER_WT) - (SW+1)'(HYST);
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_FULL - 1'b1;

  logic [SW-1:0]    sl_c, sr_c;
  logic [SW-1:0]    sum_l, sum_r;
  logic [SW:0]      abs_d;
  logic             bal, off;
  logic             present, present_nx;
  st_e              st_q, st_nx;
  logic [TMR_W-1:0] tmr, tmr_nx;
  logic             en_nx, roff_nx;

  // Masked side sums; lower half of the cells is the left side
  always_comb begin
    sl_c = '0;
    sr_c = '0;
    for (int i = 0; i < N_CELLS; i++) begin
      if (cell_en[i]) begin
        if (i < N_CELLS/2)
          sl_c = sl_c + SW'(ld_cell[i*LD_W +: LD_W]);
        else
          sr_c = sr_c + SW'(ld_cell[i*LD_W +: LD_W]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_l        <= '0;
      sum_r        <= '0;
      tot_ld       <= '0;
      ld_cell_diff <= '0;
      diff_vld     <= 1'b0;
    end else begin
      diff_vld <= cell_vld;
      if (cell_vld) begin
        sum_l        <= sl_c;
        sum_r        <= sr_c;
        tot_ld       <= {1'b0, sl_c} + {1'b0, sr_c};
        ld_cell_diff <= $signed({1'b0, sl_c})
                      - $signed({1'b0, sr_c});
      end
    end
  end

  always_comb begin
    abs_d = (sum_l >= sum_r) ? {1'b0, sum_l - sum_r}
                             : {1'b0, sum_r - sum_l};
    bal = abs_d < (tot_ld >> BAL_SHIFT);
    off = abs_d > (tot_ld - (tot_ld >> OFF_SHIFT));
  end

  // Presence follows the fresh sums so the FSM sees it in the same cycle
  always_comb begin
    present_nx = present;
    if (diff_vld) begin
      if (tot_ld > ENTER_T)
        present_nx = 1'b1;
      else if (tot_ld < EXIT_T)
        present_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      tmr       <= '0;
      present   <= 1'b0;
      en_steer  <= 1'b0;
      rider_off <= 1'b1;
    end else begin
      st_q      <= st_nx;
      tmr       <= tmr_nx;
      present   <= present_nx;
      en_steer  <= en_nx;
      rider_off <= roff_nx;
    end
  end

  always_comb begin
    st_nx  = st_q;
    tmr_nx = '0;
    unique case (st_q)
      S_IDLE: begin
        if (diff_vld && present_nx && bal)
          st_nx = S_WAIT;
      end
      S_WAIT: begin
        if (diff_vld && !present_nx)
          st_nx = S_IDLE;
        else if (diff_vld && !bal)
          tmr_nx = '0;
        else if (tmr == TMR_LAST && present_nx && bal)
          st_nx = S_STEER;
        else if (tmr != TMR_LAST)
          tmr_nx = tmr + 1'b1;
        else
          tmr_nx = tmr;
      end
      S_STEER: begin
        if (diff_vld && !present_nx)
          st_nx = S_IDLE;
        else if (diff_vld && off)
          st_nx = S_WAIT;
      end
      default: st_nx = S_IDLE;
    endcase
  end

  always_comb begin
    en_nx   = (st_nx == S_STEER);
    roff_nx = !present_nx;
  end

  assign state = st_q;

endmodule

// File: tb/tb_steer_en_mc.sv
// Scoreboard bench for steer_en_mc: directed load patterns, expected
// sums and FSM outputs queued at issue and checked by a monitor.
module tb_steer_en_mc;

  localparam int SW = 14;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [47:0]   ld_cell = '0;
  logic          cell_vld = 1'b0;
  logic [3:0]    cell_en = 4'hF;
  logic [SW:0]   tot_ld;
  logic signed [SW:0] ld_cell_diff;
  logic          diff_vld;
  logic          en_steer;
  logic          rider_off;
  logic [1:0]    state;

  typedef struct {
    int         tot;
    int         diff;
    logic [1:0] st;
    logic       es;
    logic       ro;
  } exp_t;

  exp_t sbq[$];
  exp_t pend;
  logic pend_v = 1'b0;
  int   checks = 0;
  int   errors = 0;

  steer_en_mc #(
    .N_CELLS (4),
    .LD_W    (12),
    .TMR_FULL(26'd16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ld_cell     (ld_cell),
    .cell_vld    (cell_vld),
    .cell_en     (cell_en),
    .tot_ld      (tot_ld),
    .ld_cell_diff(ld_cell_diff),
    .diff_vld    (diff_vld),
    .en_steer    (en_steer),
    .rider_off   (rider_off),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic send(
    input logic [11:0] c0, input logic [11:0] c1,
    input logic [11:0] c2, input logic [11:0] c3,
    input logic [3:0] en, input int et, input int ed,
    input logic [1:0] st, input logic es, input logic ro);
    exp_t e;
    e.tot = et; e.diff = ed; e.st = st; e.es = es; e.ro = ro;
    sbq.push_back(e);
    ld_cell  = {c3, c2, c1, c0};
    cell_en  = en;
    cell_vld = 1'b1;
    @(posedge clk); #1;
    cell_vld = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_state"}, int'(state), 0);
    chk({nm, "_en"}, int'(en_steer), 0);
    chk({nm, "_roff"}, int'(rider_off), 1);
    chk({nm, "_tot"}, int'(tot_ld), 0);
    chk({nm, "_diff"}, int'($signed(ld_cell_diff)), 0);
    chk({nm, "_dvld"}, int'(diff_vld), 0);
  endtask

  // Monitor: FSM outputs are checked on the cycle after each diff_vld
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pend_v) begin
        chk("state", int'(state), int'(pend.st));
        chk("en_steer", int'(en_steer), int'(pend.es));
        chk("rider_off", int'(rider_off), int'(pend.ro));
        pend_v = 1'b0;
      end
      if (diff_vld) begin
        if (sbq.size() == 0) begin
          chk("unexpected_diff_vld", 1, 0);
        end else begin
          e = sbq.pop_front();
          chk("tot_ld", int'(tot_ld), e.tot);
          chk("ld_cell_diff", int'($signed(ld_cell_diff)), e.diff);
          pend   = e;
          pend_v = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    idle(2);
    chk_reset("por");
    rst = 1'b0;
    idle(1);

    // balanced entry: WAIT two edges after the first sample, STEER 16 later
    for (int k = 0; k < 20; k++)
      send(12'h100, 12'h100, 12'h100, 12'h100, 4'hF, 'h400, 0,
           (k >= 16) ? 2'd2 : 2'd1, logic'(k >= 16), 1'b0);
    idle(4);
    chk("pre_rst_state", int'(state), 2);

    rst = 1'b1;
    idle(2);
    chk_reset("rst_steer");
    rst = 1'b0;
    idle(1);

    // imbalance holds the dwell, rebalance restarts it
    for (int k = 0; k < 4; k++)
      send(12'h100, 12'h100, 12'h100, 12'h100, 4'hF, 'h400, 0,
           2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++)
      send(12'h180, 12'h180, 12'h080, 12'h080, 4'hF, 'h400, 'h200,
           2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 18; k++)
      send(12'h100, 12'h100, 12'h100, 12'h100, 4'hF, 'h400, 0,
           (k >= 15) ? 2'd2 : 2'd1, logic'(k >= 15), 1'b0);
    idle(4);

    // step-off drops back to WAIT, then a fresh dwell
    for (int k = 0; k < 3; k++)
      send(12'h1FC, 12'h1FC, 12'h004, 12'h004, 4'hF, 'h400, 'h3F0,
           2'd1, 1'b0, 1'b0);
    for (int k = 0; k < 17; k++)
      send(12'h100, 12'h100, 12'h100, 12'h100, 4'hF, 'h400, 0,
           (k >= 15) ? 2'd2 : 2'd1, logic'(k >= 15), 1'b0);
    idle(4);

    // hysteresis band
    send(12'h074, 12'h074, 12'h074, 12'h074, 4'hF, 'h1D0, 0,
         2'd2, 1'b1, 1'b0);
    send(12'h06C, 12'h06C, 12'h06C, 12'h06C, 4'hF, 'h1B0, 0,
         2'd0, 1'b0, 1'b1);
    send(12'h07C, 12'h07C, 12'h07C, 12'h07C, 4'hF, 'h1F0, 0,
         2'd0, 1'b0, 1'b1);
    idle(4);

    // masked cell1 excluded; reset mid-WAIT restarts the dwell
    for (int k = 0; k < 10; k++)
      send(12'h200, 12'hFFF, 12'h100, 12'h100, 4'b1101, 'h400, 0,
           2'd1, 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk_reset("rst_wait");
    for (int k = 0; k < 20; k++)
      send(12'h200, 12'hFFF, 12'h100, 12'h100, 4'b1101, 'h400, 0,
           (k >= 16) ? 2'd2 : 2'd1, logic'(k >= 16), 1'b0);
    idle(4);

    // right-heavy step-off gives a negative difference
    send(12'h010, 12'h010, 12'h300, 12'h300, 4'hF, 'h620, -'h5E0,
         2'd1, 1'b0, 1'b0);
    idle(6);

    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/steer_en_mc.md
STEER_EN_MC -- requirements
Module: steer_en_mc

Interface
REQ-001 SHALL have parameter N_CELLS, default 4, number of load cells (even, 2..8); cells 0..N_CELLS/2-1 are left and the rest are right.
REQ-002 SHALL have parameter LD_W, default 12, width of each load-cell sample.
REQ-003 SHALL have parameter MIN_RIDER_WT, default 12'h200, the rider-present entry threshold on total load.
REQ-004 SHALL have parameter HYST, default 12'h040; rider-present exits when total load < MIN_RIDER_WT-HYST.
REQ-005 SHALL have parameter BAL_SHIFT, default 2; balanced when |diff| < tot>>BAL_SHIFT.
REQ-006 SHALL have parameter OFF_SHIFT, default 4; stepping-off when |diff| > tot-(tot>>OFF_SHIFT).
REQ-007 SHALL have parameters TMR_FULL, default 26'd67_000_000 (balance dwell, in clocks), and TMR_W, default 26.
REQ-008 SHALL have the following ports (SW = LD_W+$clog2(N_CELLS)):
  clk  in  1  clock; all logic on its rising edge.
  rst  in  1  reset: synchronous, active-high.
  ld_cell  in  N_CELLS*LD_W  packed unsigned samples; cell i is at [i*LD_W +: LD_W].
  cell_vld  in  1  one-cycle strobe; ld_cell is valid.
  cell_en  in  N_CELLS  per-cell enable mask; a disabled cell contributes 0.
  tot_ld  out  SW+1  registered left+right sum.
  ld_cell_diff  out  SW+1 signed  registered left-right.
  diff_vld  out  1  one-cycle pulse when tot_ld/ld_cell_diff update.
  en_steer  out  1  steering enabled.
  rider_off  out  1  rider absent.
  state  out  2  FSM state: IDLE=0, WAIT=1, STEER=2.

Function
REQ-009 On cell_vld at edge n, SHALL register sum_l, sum_r, tot_ld and ld_cell_diff at edge n+1 and pulse diff_vld for that one cycle.
REQ-010 When cell_vld=0, SHALL hold sums and outputs; diff_vld SHALL be 0.
REQ-011 Sums SHALL be computed at full width with no overflow; ld_cell_diff SHALL be sign-extended.
REQ-012 SHALL compute flags combinationally from the registered sums:
  - present (registered, with hysteresis): set when tot_ld > MIN_RIDER_WT; clear when tot_ld < MIN_RIDER_WT-HYST; updated only on the diff_vld cycle.
  - bal: as defined in REQ-005.
  - off: as defined in REQ-006.
REQ-013 SHALL implement the rider_off output as the registered inverse of present.
REQ-014 FSM transitions SHALL be evaluated on diff_vld cycles only; the dwell timer SHALL advance every clock while in WAIT.
REQ-015 In IDLE: if present and bal, SHALL go to WAIT with the timer cleared.
REQ-016 In WAIT:
  - if not present -> IDLE.
  - else if not bal -> clear the timer and remain in WAIT.
  - else if the timer reaches TMR_FULL-1 -> STEER (on any clock, not gated by diff_vld).
REQ-017 In STEER:
  - if not present -> IDLE.
  - else if off -> WAIT with the timer cleared.
REQ-018 SHALL register en_steer as (next_state==STEER), so it changes on the same edge as state.
REQ-019 If the timer expiry and a failing flag occur in the same cycle, the flag SHALL take priority (no entry to STEER).
REQ-020 The timer SHALL saturate and never wrap; the timer SHALL be 0 in any state other than WAIT.
REQ-021 A cell_en change SHALL take effect on the next cell_vld only.
REQ-022 Worst-case latency from cell_vld to en_steer/rider_off change SHALL be 2 clocks.

Reset
REQ-023 While rst=1 at a clock edge, SHALL drive:
  - state=IDLE, timer=0, present=0;
  - tot_ld=0, ld_cell_diff=0, diff_vld=0;
  - en_steer=0, rider_off=1.
REQ-024 A reset asserted in WAIT or STEER SHALL abort immediately; no residual timer count SHALL survive.

Verification (N_CELLS=4, LD_W=12, defaults except TMR_FULL=16)
REQ-025 Reset test: rst=1 for 2 clocks in STEER -> state=0, en_steer=0, rider_off=1, tot_ld=0, ld_cell_diff=0.
REQ-026 Balanced entry test: all cells 0x100, cell_vld every clock -> tot_ld=0x400, diff=0, WAIT entered; en_steer rises exactly 16 clocks after WAIT entry.
REQ-027 Imbalance test:
  - left cells 0x180, right cells 0x080 -> diff=0x200 >= 0x100, timer held at 0, en_steer stays 0;
  - then rebalance -> full 16-clock dwell again.
REQ-028 Step-off test: in STEER, left cells 0x1FC, right cells 0x004 -> diff=0x3F0 > 0x3C0, state=WAIT and en_steer=0 within 2 clocks of cell_vld.
REQ-029 Hysteresis test:
  - tot_ld falls to 0x1D0 -> rider_off stays 0;
  - tot_ld falls to 0x1B0 -> rider_off=1, state=IDLE;
  - tot_ld rises to 0x1F0 -> stays IDLE (threshold not crossed).
REQ-030 Mask/abort test:
  - cell_en=4'b1101 with cell1=0xFFF -> cell1 excluded from sums;
  - rst pulsed mid-WAIT at timer=10 -> after release, the dwell restarts from 0.
